// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous word RAM between the instruction-fetch port and the
//   data load/store port. One RAM access is granted per cycle; read data returns one cycle
//   after the grant and the losing requester is stalled.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   if_req/if_addr                   fetch request and byte address
//   if_stall/if_rdata/if_rvalid      fetch stall, read data, one-cycle data-valid pulse
//   d_re/d_raddr                     load request and byte address
//   d_we/d_waddr/d_wdata/d_wstrb     store request, byte address, data, byte enables
//   d_stall/d_rdata/d_rvalid         data stall, load data, one-cycle data-valid pulse
//   mem_en/mem_we/mem_wstrb          RAM access, write enable, byte enables
//   mem_addr/mem_wdata/mem_rdata     RAM word address, write data, read data
module mem_port_arbiter #(
    parameter int unsigned AW         = 12,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic          if_stall,
    output logic [31:0]   if_rdata,
    output logic          if_rvalid,
    input  logic          d_re,
    input  logic [31:0]   d_raddr,
    input  logic          d_we,
    input  logic [31:0]   d_waddr,
    input  logic [31:0]   d_wdata,
    input  logic [3:0]    d_wstrb,
    output logic          d_stall,
    output logic [31:0]   d_rdata,
    output logic          d_rvalid,
    output logic          mem_en,
    output logic          mem_we,
    output logic [3:0]    mem_wstrb,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    typedef enum logic [1:0] {OwnNone, OwnIf, OwnD} own_e;

    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       st_done_q, st_done_d;
    own_e       rd_own_q, rd_own_d;

    logic fetch_pri, st_gnt, ld_gnt, if_gnt;

    // Byte-offset bits and bits above the RAM range are intentionally ignored (address wraps).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:AW+2], if_addr[1:0], d_raddr[31:AW+2], d_raddr[1:0],
                                d_waddr[31:AW+2], d_waddr[1:0]};

    // Fixed-priority grant; every grant is suppressed while reset is asserted.
    always_comb begin
        fetch_pri = rst_n && if_req && (starve_cnt_q == StarveMax);
        st_gnt    = rst_n && !fetch_pri && d_we && !st_done_q;
        ld_gnt    = rst_n && !fetch_pri && !st_gnt && d_re;
        if_gnt    = fetch_pri || (rst_n && if_req && !st_gnt && !ld_gnt);
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        st_done_d    = st_done_q;
        rd_own_d     = OwnNone;
        if (!if_req || if_gnt) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q < StarveMax) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
        // st_done remembers that the store half of a combined load+store already went out.
        if (ld_gnt || !d_re) begin
            st_done_d = 1'b0;
        end else if (st_gnt) begin
            st_done_d = 1'b1;
        end
        if (if_gnt) begin
            rd_own_d = OwnIf;
        end else if (ld_gnt) begin
            rd_own_d = OwnD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt_q <= 4'd0;
            st_done_q    <= 1'b0;
            rd_own_q     <= OwnNone;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            st_done_q    <= st_done_d;
            rd_own_q     <= rd_own_d;
        end
    end

    always_comb begin
        mem_en    = st_gnt || ld_gnt || if_gnt;
        mem_we    = st_gnt;
        mem_wstrb = 4'd0;
        mem_wdata = 32'd0;
        mem_addr  = '0;
        if (st_gnt) begin
            mem_addr  = d_waddr[AW+1:2];
            mem_wstrb = d_wstrb;
            mem_wdata = d_wdata;
        end else if (ld_gnt) begin
            mem_addr = d_raddr[AW+1:2];
        end else if (if_gnt) begin
            mem_addr = if_addr[AW+1:2];
        end

        if_stall = rst_n && if_req && !if_gnt;
        d_stall  = rst_n && (d_re || d_we) && !(ld_gnt || (st_gnt && !d_re));

        if_rvalid = rst_n && (rd_own_q == OwnIf);
        d_rvalid  = rst_n && (rd_own_q == OwnD);
        if_rdata  = if_rvalid ? mem_rdata : 32'd0;
        d_rdata   = d_rvalid ? mem_rdata : 32'd0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with a behavioural RAM. Expected read data is queued
//   at grant time and popped when the matching rvalid pulse appears.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_stall;
    logic [31:0]   if_rdata;
    logic          if_rvalid;
    logic          d_re;
    logic [31:0]   d_raddr;
    logic          d_we;
    logic [31:0]   d_waddr;
    logic [31:0]   d_wdata;
    logic [3:0]    d_wstrb;
    logic          d_stall;
    logic [31:0]   d_rdata;
    logic          d_rvalid;
    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_wstrb;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] if_q [$];
    logic [31:0] d_q  [$];
    logic [31:0] ram  [0:(1<<AW)-1];

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .STARVE_MAX(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_stall  (if_stall),
        .if_rdata  (if_rdata),
        .if_rvalid (if_rvalid),
        .d_re      (d_re),
        .d_raddr   (d_raddr),
        .d_we      (d_we),
        .d_waddr   (d_waddr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_stall   (d_stall),
        .d_rdata   (d_rdata),
        .d_rvalid  (d_rvalid),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_wstrb (mem_wstrb),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Behavioural single-port RAM with byte enables and one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wstrb[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    function automatic logic [31:0] init_word(input int unsigned idx);
        return 32'hC0DE_0000 | 32'(idx);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every rvalid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (if_rvalid) begin
            if (if_q.size() == 0) check("if_rvalid_unexpected", 32'(if_rvalid), 32'd0);
            else check("if_rdata", if_rdata, if_q.pop_front());
        end
        if (d_rvalid) begin
            if (d_q.size() == 0) check("d_rvalid_unexpected", 32'(d_rvalid), 32'd0);
            else check("d_rdata", d_rdata, d_q.pop_front());
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = 32'd0;
        d_re = 1'b0; d_raddr = 32'd0;
        d_we = 1'b0; d_waddr = 32'd0; d_wdata = 32'd0; d_wstrb = 4'd0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
        check({tag, "_if_stall"}, 32'(if_stall), 32'd0);
        check({tag, "_d_stall"}, 32'(d_stall), 32'd0);
        check({tag, "_if_rvalid"}, 32'(if_rvalid), 32'd0);
        check({tag, "_d_rvalid"}, 32'(d_rvalid), 32'd0);
        check({tag, "_if_rdata"}, if_rdata, 32'd0);
        check({tag, "_d_rdata"}, d_rdata, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = init_word(i);
        idle_inputs();
        rst_n = 1'b0;

        // Reset with requests present: everything must stay quiet.
        if_req = 1'b1; if_addr = 32'h40; d_re = 1'b1; d_raddr = 32'h100;
        next_cycle();
        @(negedge clk);
        check_all_zero("reset");
        next_cycle();
        idle_inputs();
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_mem_en", 32'(mem_en), 32'd0);
        next_cycle();

        // 1: back-to-back fetches.
        for (int k = 0; k < 3; k++) begin
            if_req = 1'b1; if_addr = 32'h40 + 32'(4 * k);
            @(negedge clk);
            check("t1_mem_addr", 32'(mem_addr), 32'h10 + 32'(k));
            check("t1_if_stall", 32'(if_stall), 32'd0);
            check("t1_mem_en", 32'(mem_en), 32'd1);
            if_q.push_back(init_word(32'h10 + k));
            next_cycle();
        end
        idle_inputs();
        next_cycle();

        // 2: load beats fetch, fetch goes next.
        d_re = 1'b1; d_raddr = 32'h100; if_req = 1'b1; if_addr = 32'h44;
        @(negedge clk);
        check("t2_ld_addr", 32'(mem_addr), 32'h40);
        check("t2_if_stall", 32'(if_stall), 32'd1);
        check("t2_d_stall", 32'(d_stall), 32'd0);
        d_q.push_back(init_word(32'h40));
        next_cycle();
        d_re = 1'b0;
        @(negedge clk);
        check("t2_if_addr", 32'(mem_addr), 32'h11);
        check("t2_if_stall2", 32'(if_stall), 32'd0);
        if_q.push_back(init_word(32'h11));
        next_cycle();
        idle_inputs();
        next_cycle();

        // 3: starvation limit, fetch denied three times then wins.
        d_re = 1'b1; d_raddr = 32'h100; if_req = 1'b1; if_addr = 32'h48;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t3_if_stall", 32'(if_stall), (k < 3) ? 32'd1 : 32'd0);
            check("t3_d_stall", 32'(d_stall), (k < 3) ? 32'd0 : 32'd1);
            if (k < 3) d_q.push_back(init_word(32'h40));
            else begin
                check("t3_if_addr", 32'(mem_addr), 32'h12);
                if_q.push_back(init_word(32'h12));
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();

        // 4: store + load same address: store first, then load sees new data.
        d_we = 1'b1; d_waddr = 32'h200; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
        d_re = 1'b1; d_raddr = 32'h200;
        @(negedge clk);
        check("t4_st_we", 32'(mem_we), 32'd1);
        check("t4_st_addr", 32'(mem_addr), 32'h80);
        check("t4_st_wdata", mem_wdata, 32'hDEADBEEF);
        check("t4_st_d_stall", 32'(d_stall), 32'd1);
        next_cycle();
        @(negedge clk);
        check("t4_ld_we", 32'(mem_we), 32'd0);
        check("t4_ld_wstrb", 32'(mem_wstrb), 32'd0);
        check("t4_ld_addr", 32'(mem_addr), 32'h80);
        check("t4_ld_d_stall", 32'(d_stall), 32'd0);
        d_q.push_back(32'hDEADBEEF);
        next_cycle();
        idle_inputs();
        next_cycle();

        // 5: partial-byte store, then a zero-strobe store that must still take a slot.
        d_we = 1'b1; d_waddr = 32'h300; d_wdata = 32'hFFFFFFFF; d_wstrb = 4'hF;
        @(negedge clk);
        check("t5_full_d_stall", 32'(d_stall), 32'd0);
        next_cycle();
        d_wdata = 32'h1234ABCD; d_wstrb = 4'h3;
        @(negedge clk);
        check("t5_part_wstrb", 32'(mem_wstrb), 32'h3);
        next_cycle();
        d_wdata = 32'h0; d_wstrb = 4'h0;
        @(negedge clk);
        check("t5_zero_en", 32'(mem_en), 32'd1);
        check("t5_zero_we", 32'(mem_we), 32'd1);
        check("t5_zero_wstrb", 32'(mem_wstrb), 32'd0);
        next_cycle();
        idle_inputs();
        d_re = 1'b1; d_raddr = 32'h300;
        @(negedge clk);
        check("t5_ld_addr", 32'(mem_addr), 32'hC0);
        d_q.push_back(32'hFFFFABCD);
        next_cycle();
        idle_inputs();
        next_cycle();

        // 6: saturate starvation, reset right after a load grant.
        d_re = 1'b1; d_raddr = 32'h104; if_req = 1'b1; if_addr = 32'h4C;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t6_pre_if_stall", 32'(if_stall), 32'd1);
            if (k < 2) d_q.push_back(init_word(32'h41));
            next_cycle();
        end
        rst_n = 1'b0; d_re = 1'b0;
        @(negedge clk);
        check_all_zero("t6_reset");
        next_cycle();
        rst_n = 1'b1; d_re = 1'b1;
        @(negedge clk);
        check("t6_post_if_stall", 32'(if_stall), 32'd1);
        check("t6_post_ld_addr", 32'(mem_addr), 32'h41);
        d_q.push_back(init_word(32'h41));
        next_cycle();
        d_re = 1'b0;
        @(negedge clk);
        check("t6_post_fetch_stall", 32'(if_stall), 32'd0);
        check("t6_post_fetch_addr", 32'(mem_addr), 32'h13);
        if_q.push_back(init_word(32'h13));
        next_cycle();
        idle_inputs();
        repeat (3) next_cycle();

        check("if_q_drained", 32'(if_q.size()), 32'd0);
        check("d_q_drained", 32'(d_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
